// File: rtl/shoot_pkg.sv
// Shared definitions for the shoot command path (shoot_trigger and the kick
// driver).
//   shoot_state_e        : command FSM states
//   ST_*                 : completion status codes reported with done
//   STRENGTH_CHIP_BIT    : strength bit selecting chip (1) or flat shot (0)
//   DRIVER_LOCKOUT_TICKS : ticks the kick driver ignores a new en rising edge
//                          after a trigger
package shoot_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } shoot_state_e;

  localparam logic [1:0] ST_FIRED   = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_CANCEL  = 2'b10;
  localparam logic [1:0] ST_REJECT  = 2'b11;

  localparam int unsigned STRENGTH_CHIP_BIT    = 7;
  localparam int unsigned DRIVER_LOCKOUT_TICKS = 10000;

  // A command is only worth firing if its duration field is non-zero.
  function automatic logic strength_valid(input logic [7:0] s);
    return s[STRENGTH_CHIP_BIT-1:0] != '0;
  endfunction

endpackage

// File: rtl/shoot_tick_gen.sv
// Tick prescaler shared by the shoot trigger and the kick driver.
//   clk0  : system clock
//   rst_n : asynchronous reset, active-low
//   clr   : restart the prescaler; the next tick comes TICK_DIV clocks after
//           the edge that sampled clr
//   tick  : high for one clk0 cycle every TICK_DIV cycles
module shoot_tick_gen #(
  parameter int unsigned TICK_DIV = 2501
) (
  input  logic clk0,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] div_cnt;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    tick = (div_cnt == DIV_LAST);
  end

endmodule

// File: rtl/shoot_trigger.sv
// Upstream command stage for the kick driver.
// Accepts a one-shot kick/chip command, optionally waits for a debounced ball
// sensor and capacitor-ready, then presents a stable strength byte and an en
// pulse to the driver, holds a cooldown covering the driver's re-trigger
// lockout and reports completion status.
//   clk0, rst_n      : clock, asynchronous active-low reset
//   cmd_valid        : one-cycle command strobe
//   cmd_strength     : [7] chip/flat, [6:0] duration in ticks
//   cmd_arm          : wait for ball_present before firing
//   cmd_cancel       : one-cycle abort strobe (honoured only while ARMED)
//   ball_detect      : raw asynchronous infrared sensor
//   cap_ready        : capacitor charged
//   strength         : to driver, updated only on command acceptance
//   en               : trigger pulse to driver, EN_PULSE_CLKS wide
//   busy             : high outside IDLE
//   charge_inhibit   : high through FIRE and COOLDOWN
//   ball_present     : debounced ball_detect
//   done/done_status : one-cycle completion pulse with status code
module shoot_trigger
  import shoot_pkg::*;
#(
  parameter int unsigned TICK_DIV          = 2501,
  parameter int unsigned DEBOUNCE_CLKS     = 16,
  parameter int unsigned EN_PULSE_CLKS     = 4,
  parameter int unsigned COOLDOWN_TICKS    = 10002,
  parameter int unsigned ARM_TIMEOUT_TICKS = 20000
) (
  input  logic       clk0,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_strength,
  input  logic       cmd_arm,
  input  logic       cmd_cancel,
  input  logic       ball_detect,
  input  logic       cap_ready,
  output logic [7:0] strength,
  output logic       en,
  output logic       busy,
  output logic       charge_inhibit,
  output logic       ball_present,
  output logic       done,
  output logic [1:0] done_status
);

  localparam int unsigned DW  = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
  localparam int unsigned PCW = (EN_PULSE_CLKS > 1) ? $clog2(EN_PULSE_CLKS) : 1;

  localparam logic [DW-1:0]  DEB_LAST   = DW'(DEBOUNCE_CLKS - 1);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(EN_PULSE_CLKS - 1);
  localparam logic [15:0]    COOL_LAST  = 16'(COOLDOWN_TICKS - 1);
  localparam logic [15:0]    ARM_LAST   =
    (ARM_TIMEOUT_TICKS == 0) ? 16'd0 : 16'(ARM_TIMEOUT_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Ball sensor: two-flop synchroniser followed by a run-length debounce.
  // ---------------------------------------------------------------------------
  logic          ball_meta;
  logic          ball_sync;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      ball_meta    <= 1'b0;
      ball_sync    <= 1'b0;
      deb_cnt      <= '0;
      ball_present <= 1'b0;
    end else begin
      ball_meta <= ball_detect;
      ball_sync <= ball_meta;
      if (ball_sync == ball_present) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt      <= '0;
        ball_present <= ball_sync;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tick time base.
  // ---------------------------------------------------------------------------
  logic tick;
  logic tick_clr;

  shoot_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk0  (clk0),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // Command FSM.
  // ---------------------------------------------------------------------------
  shoot_state_e   state_q;
  shoot_state_e   state_d;
  logic           arm_r;
  logic [15:0]    tick_cnt;
  logic [PCW-1:0] pulse_cnt;

  logic       fire_ok;
  logic       timeout_hit;
  logic       pulse_last;
  logic       cooldown_last;
  logic       cmd_accept;
  logic       done_d;
  logic [1:0] status_d;
  logic       en_d;
  logic       busy_d;
  logic       inhibit_d;

  always_comb begin
    fire_ok       = cap_ready & (ball_present | ~arm_r);
    timeout_hit   = (ARM_TIMEOUT_TICKS != 0) && tick && (tick_cnt == ARM_LAST);
    pulse_last    = (pulse_cnt == PULSE_LAST);
    cooldown_last = tick && (tick_cnt == COOL_LAST);
    cmd_accept    = (state_q == IDLE) && cmd_valid && strength_valid(cmd_strength);
  end

  // State register together with the registered outputs, so en/busy/
  // charge_inhibit/done change on the same edge as the state they describe.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      en             <= 1'b0;
      busy           <= 1'b0;
      charge_inhibit <= 1'b0;
      done           <= 1'b0;
      done_status    <= '0;
      strength       <= '0;
      arm_r          <= 1'b0;
    end else begin
      state_q        <= state_d;
      en             <= en_d;
      busy           <= busy_d;
      charge_inhibit <= inhibit_d;
      done           <= done_d;
      done_status    <= status_d;
      if (cmd_accept) begin
        strength <= cmd_strength;
        arm_r    <= cmd_arm;
      end
    end
  end

  // Next state. In ARMED the branch order sets precedence:
  // cancel over fire, fire over timeout.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    status_d = done_status;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (strength_valid(cmd_strength)) begin
            state_d = ARMED;
          end else begin
            done_d   = 1'b1;
            status_d = ST_REJECT;
          end
        end
      end
      ARMED: begin
        if (cmd_cancel) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          status_d = ST_CANCEL;
        end else if (fire_ok) begin
          state_d = FIRE;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          status_d = ST_TIMEOUT;
        end
      end
      FIRE: begin
        if (pulse_last) begin
          state_d  = COOLDOWN;
          done_d   = 1'b1;
          status_d = ST_FIRED;
        end
      end
      COOLDOWN: begin
        if (cooldown_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state; the values land in the output
  // registers on the transition edge. The prescaler restarts on entry to the
  // tick-timed states so the first tick comes exactly TICK_DIV clocks later.
  always_comb begin
    en_d      = (state_d == FIRE);
    busy_d    = (state_d != IDLE);
    inhibit_d = (state_d == FIRE) || (state_d == COOLDOWN);
    tick_clr  = (state_d != state_q) &&
                ((state_d == ARMED) || (state_d == COOLDOWN));
  end

  // Per-state counters, cleared on every state change.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      pulse_cnt <= '0;
    end else if (state_d != state_q) begin
      tick_cnt  <= '0;
      pulse_cnt <= '0;
    end else begin
      if (tick) begin
        tick_cnt <= tick_cnt + 16'd1;
      end
      if (state_q == FIRE) begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shoot_trigger.sv
// Self-checking bench for shoot_trigger: directed scenarios followed by
// random command/sensor traffic, checked every cycle against a timeline model
// that works from elapsed clock counts since each phase began.
module tb_shoot_trigger;

  localparam int TB_TICK_DIV = 10;
  localparam int TB_DEB      = 4;
  localparam int TB_EN       = 4;
  localparam int TB_COOL     = 12;
  localparam int TB_TIMEOUT  = 5;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_FIRE  = 2;
  localparam int P_COOL  = 3;

  logic       clk0 = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_strength;
  logic       cmd_arm;
  logic       cmd_cancel;
  logic       ball_detect;
  logic       cap_ready;
  logic [7:0] strength;
  logic       en;
  logic       busy;
  logic       charge_inhibit;
  logic       ball_present;
  logic       done;
  logic [1:0] done_status;

  shoot_trigger #(
    .TICK_DIV          (TB_TICK_DIV),
    .DEBOUNCE_CLKS     (TB_DEB),
    .EN_PULSE_CLKS     (TB_EN),
    .COOLDOWN_TICKS    (TB_COOL),
    .ARM_TIMEOUT_TICKS (TB_TIMEOUT)
  ) dut (
    .clk0           (clk0),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_strength   (cmd_strength),
    .cmd_arm        (cmd_arm),
    .cmd_cancel     (cmd_cancel),
    .ball_detect    (ball_detect),
    .cap_ready      (cap_ready),
    .strength       (strength),
    .en             (en),
    .busy           (busy),
    .charge_inhibit (charge_inhibit),
    .ball_present   (ball_present),
    .done           (done),
    .done_status    (done_status)
  );

  always #5 clk0 = ~clk0;

  int n_vec = 0;
  int n_err = 0;

  // Model state: current phase and the edge at which it began.
  longint     cyc;
  longint     m_enter;
  int         m_phase;
  logic [7:0] m_strength;
  logic       m_arm;
  logic       m_present;
  logic       m_done;
  logic [1:0] m_status;
  logic       raw_hist[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    m_enter    = 0;
    m_phase    = P_IDLE;
    m_strength = '0;
    m_arm      = 1'b0;
    m_present  = 1'b0;
    m_done     = 1'b0;
    m_status   = 2'b00;
    raw_hist.delete();
    for (int i = 0; i < TB_DEB + 2; i++) raw_hist.push_back(1'b0);
  endtask

  // One clock edge of the reference behaviour, using the inputs as sampled
  // at that edge.
  task automatic model_step();
    longint     el;
    int         nxt;
    logic       dn;
    logic [1:0] st;
    logic       flip;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cyc++;
    el  = cyc - m_enter;
    nxt = m_phase;
    dn  = 1'b0;
    st  = 2'b00;
    case (m_phase)
      P_IDLE: if (cmd_valid) begin
        if (cmd_strength[6:0] == 7'd0) begin
          dn = 1'b1; st = 2'b11;
        end else begin
          m_strength = cmd_strength;
          m_arm      = cmd_arm;
          nxt        = P_ARMED;
        end
      end
      P_ARMED: begin
        if (cmd_cancel) begin
          dn = 1'b1; st = 2'b10; nxt = P_IDLE;
        end else if (cap_ready && (m_present || !m_arm)) begin
          nxt = P_FIRE;
        end else if (TB_TIMEOUT != 0 && el == longint'(TB_TICK_DIV * TB_TIMEOUT)) begin
          dn = 1'b1; st = 2'b01; nxt = P_IDLE;
        end
      end
      P_FIRE: if (el == longint'(TB_EN)) begin
        dn = 1'b1; st = 2'b00; nxt = P_COOL;
      end
      default: if (el == longint'(TB_TICK_DIV * TB_COOL)) nxt = P_IDLE;
    endcase
    if (nxt != m_phase) m_enter = cyc;
    m_phase = nxt;
    m_done  = dn;
    if (dn) m_status = st;
    // Sensor: the level seen by the debouncer lags the pin by two edges; the
    // debounced value flips once the last TB_DEB such samples all disagree.
    raw_hist.push_front(ball_detect);
    void'(raw_hist.pop_back());
    flip = 1'b1;
    for (int i = 2; i < TB_DEB + 2; i++) begin
      if (raw_hist[i] == m_present) flip = 1'b0;
    end
    if (flip) m_present = ~m_present;
  endtask

  task automatic compare_outputs();
    check("strength",       strength,       m_strength);
    check("en",             8'(en),         8'(m_phase == P_FIRE));
    check("busy",           8'(busy),       8'(m_phase != P_IDLE));
    check("charge_inhibit", 8'(charge_inhibit),
          8'(m_phase == P_FIRE || m_phase == P_COOL));
    check("ball_present",   8'(ball_present), 8'(m_present));
    check("done",           8'(done),       8'(m_done));
    if (m_done) check("done_status", 8'(done_status), 8'(m_status));
  endtask

  // Compare on the falling edge, then let one rising edge happen. Returns 1
  // time unit after the rising edge so callers can change inputs safely.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk0);
      compare_outputs();
      @(posedge clk0);
      model_step();
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] s, input logic arm);
    cmd_valid    = 1'b1;
    cmd_strength = s;
    cmd_arm      = arm;
    step();
    cmd_valid    = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_strength = '0;
    cmd_arm      = 1'b0;
    cmd_cancel   = 1'b0;
    ball_detect  = 1'b0;
    cap_ready    = 1'b0;
    model_reset();
    step(3);
    rst_n = 1'b1;
    step(2);

    // Immediate shot.
    cap_ready = 1'b1;
    send_cmd(8'h85, 1'b0);
    step(140);

    // Armed shot: short ball glitch, then a solid ball.
    send_cmd(8'h10, 1'b1);
    step(3);
    ball_detect = 1'b1;
    step(3);
    ball_detect = 1'b0;
    step(10);
    ball_detect = 1'b1;
    step(140);
    ball_detect = 1'b0;
    step(10);

    // Armed timeout with no ball.
    send_cmd(8'h22, 1'b1);
    step(60);

    // Re-arm, cancel on the cycle the debounced ball first reads present.
    send_cmd(8'h33, 1'b1);
    step(2);
    ball_detect = 1'b1;
    step(6);
    cmd_cancel = 1'b1;
    step();
    cmd_cancel = 1'b0;
    step(5);
    ball_detect = 1'b0;
    step(10);

    // Zero-duration reject, then commands/cancels during cooldown.
    send_cmd(8'h80, 1'b0);
    step(3);
    send_cmd(8'h41, 1'b0);
    step(20);
    send_cmd(8'h55, 1'b0);
    cmd_cancel = 1'b1;
    step();
    cmd_cancel = 1'b0;
    step(40);
    send_cmd(8'h00, 1'b1);
    step(80);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid    = ($urandom_range(0, 19) == 0);
      cmd_strength = 8'($urandom);
      if ($urandom_range(0, 5) == 0) cmd_strength[6:0] = 7'd0;
      cmd_arm      = 1'($urandom_range(0, 1));
      cmd_cancel   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 29) == 0) cap_ready = ~cap_ready;
      if ($urandom_range(0, 7) == 0) ball_detect = ~ball_detect;
      step();
    end

    // Quiet down to IDLE, then reset in the middle of the en pulse.
    cmd_valid   = 1'b0;
    cmd_cancel  = 1'b0;
    ball_detect = 1'b0;
    cap_ready   = 1'b1;
    step(260);
    send_cmd(8'h9A, 1'b0);
    step();
    check("en_pre_reset", 8'(en), 8'(m_phase == P_FIRE));
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    step(2);
    rst_n = 1'b1;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
